// File: rtl/logic_exerciser.sv
// logic_exerciser: self-test sequencer for the majority(~A,C,D) block.
// Sweeps all 8 {A,C,D} vectors, holds each for HOLD_CYCLES cycles, then
// spends one CHECK cycle comparing F1/F2 against a golden model.
// Optional macro FIRST_FAIL_EN adds first_fail / first_fail_vld reporting.
`timescale 1ns/1ps

module logic_exerciser #(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       f1_in,
  input  logic       f2_in,
  output logic       a_out,
  output logic       c_out,
  output logic       d_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [2:0] vec_idx
`ifdef FIRST_FAIL_EN
  ,
  output logic [2:0] first_fail,
  output logic       first_fail_vld
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

  state_t     state_q, state_d;
  logic [2:0] vec_q, vec_d;
  logic [3:0] hold_q, hold_d;
  logic [3:0] err_q, err_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;

  logic       exp_val;
  logic       mismatch;
  logic [3:0] err_inc;

`ifdef FIRST_FAIL_EN
  logic [2:0] ff_q, ff_d;
  logic       ffv_q, ffv_d;
`endif

  // Golden model on the currently driven vector and per-vector error flag.
  always_comb begin
    exp_val  = (~vec_q[2] & vec_q[0]) | (~vec_q[2] & vec_q[1]) | (vec_q[1] & vec_q[0]);
    mismatch = (f1_in != exp_val) || (f2_in != exp_val);
    err_inc  = err_q + 4'(mismatch);
  end

  // Next-state and next-output logic for the sweep sequencer.
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    hold_d  = hold_q;
    err_d   = err_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
`ifdef FIRST_FAIL_EN
    ff_d    = ff_q;
    ffv_d   = ffv_q;
`endif
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_SETTLE;
          vec_d   = '0;
          hold_d  = '0;
          err_d   = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
`ifdef FIRST_FAIL_EN
          ff_d    = '0;
          ffv_d   = 1'b0;
`endif
        end
      end
      S_SETTLE: begin
        hold_d = hold_q + 4'd1;
        if (hold_q == HOLD_LAST) begin
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        err_d = err_inc;
`ifdef FIRST_FAIL_EN
        if (mismatch && !ffv_q) begin
          ff_d  = vec_q;
          ffv_d = 1'b1;
        end
`endif
        if (vec_q == 3'd7) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_inc == 4'd0);
        end else begin
          state_d = S_SETTLE;
          vec_d   = vec_q + 3'd1;
          hold_d  = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      hold_q  <= '0;
      err_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
`ifdef FIRST_FAIL_EN
      ff_q    <= '0;
      ffv_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      hold_q  <= hold_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
`ifdef FIRST_FAIL_EN
      ff_q    <= ff_d;
      ffv_q   <= ffv_d;
`endif
    end
  end

  // Vector outputs come straight from the vector register: {A,C,D} = vec_idx.
  assign a_out     = vec_q[2];
  assign c_out     = vec_q[1];
  assign d_out     = vec_q[0];
  assign vec_idx   = vec_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
`ifdef FIRST_FAIL_EN
  assign first_fail     = ff_q;
  assign first_fail_vld = ffv_q;
`endif

endmodule

// File: tb/tb_logic_exerciser.sv
// Directed bench for logic_exerciser: a default instance (HOLD_CYCLES=4) and
// a HOLD_CYCLES=1 instance, each fed by a table-driven combinational block
// with selectable fault modes (0 = correct, 1 = F1 stuck at 0, 2 = F2 inverted).
`timescale 1ns/1ps

module tb_logic_exerciser;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic start_m, start_h;
  int   mode;
  bit   sel;
  int   checks   = 0;
  int   failures = 0;

  // Truth table of majority(~A,C,D) indexed by {A,C,D}: ones at 1,2,3,7.
  logic [7:0] exp_tab = 8'b1000_1110;

  logic m_f1, m_f2, m_a, m_c, m_d, m_busy, m_done, m_pass;
  logic [3:0] m_err;
  logic [2:0] m_vec;
  logic h_f1, h_f2, h_a, h_c, h_d, h_busy, h_done, h_pass;
  logic [3:0] h_err;
  logic [2:0] h_vec;
`ifdef FIRST_FAIL_EN
  logic [2:0] m_ff, h_ff;
  logic       m_ffv, h_ffv;
`endif

  assign m_f1 = (mode == 1) ? 1'b0 : exp_tab[{m_a, m_c, m_d}];
  assign m_f2 = (mode == 2) ? ~exp_tab[{m_a, m_c, m_d}] : exp_tab[{m_a, m_c, m_d}];
  assign h_f1 = (mode == 1) ? 1'b0 : exp_tab[{h_a, h_c, h_d}];
  assign h_f2 = (mode == 2) ? ~exp_tab[{h_a, h_c, h_d}] : exp_tab[{h_a, h_c, h_d}];

  logic s_a, s_c, s_d, s_busy, s_done, s_pass;
  logic [3:0] s_err;
  logic [2:0] s_vec;
  assign s_a    = sel ? h_a    : m_a;
  assign s_c    = sel ? h_c    : m_c;
  assign s_d    = sel ? h_d    : m_d;
  assign s_busy = sel ? h_busy : m_busy;
  assign s_done = sel ? h_done : m_done;
  assign s_pass = sel ? h_pass : m_pass;
  assign s_err  = sel ? h_err  : m_err;
  assign s_vec  = sel ? h_vec  : m_vec;

  logic_exerciser #(.HOLD_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .start(start_m), .f1_in(m_f1), .f2_in(m_f2),
    .a_out(m_a), .c_out(m_c), .d_out(m_d), .busy(m_busy), .done(m_done),
    .pass(m_pass), .err_count(m_err), .vec_idx(m_vec)
`ifdef FIRST_FAIL_EN
    , .first_fail(m_ff), .first_fail_vld(m_ffv)
`endif
  );

  logic_exerciser #(.HOLD_CYCLES(1)) dut_h1 (
    .clk(clk), .rst(rst), .start(start_h), .f1_in(h_f1), .f2_in(h_f2),
    .a_out(h_a), .c_out(h_c), .d_out(h_d), .busy(h_busy), .done(h_done),
    .pass(h_pass), .err_count(h_err), .vec_idx(h_vec)
`ifdef FIRST_FAIL_EN
    , .first_fail(h_ff), .first_fail_vld(h_ffv)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept a start, follow the sweep to done (bounded), checking latency,
  // vector order/duration, a/c/d mapping and busy along the way.
  task automatic run_sweep(input bit use_h1, input int hold, input bit hold_start);
    int cnt[8];
    int cycles, bad_acd, bad_busy, bad_order, bad_cnt;
    logic [2:0] prev;
    sel = use_h1;
    if (use_h1) start_h = 1'b1; else start_m = 1'b1;
    tick();
    if (!hold_start) begin start_m = 1'b0; start_h = 1'b0; end
    checks++;
    if (s_busy !== 1'b1 || s_done !== 1'b0 || s_err !== 4'd0 || s_vec !== 3'd0) begin
      failures++;
      $display("FAIL accept: busy=%b done=%b err=%0d vec=%0d, required busy=1 done=0 err=0 vec=0",
               s_busy, s_done, s_err, s_vec);
    end
    for (int i = 0; i < 8; i++) cnt[i] = 0;
    cycles = 0; bad_acd = 0; bad_busy = 0; bad_order = 0; prev = 3'd0;
    while (s_done !== 1'b1 && cycles < 200) begin
      cnt[s_vec]++;
      if ({s_a, s_c, s_d} !== s_vec) bad_acd++;
      if (s_busy !== 1'b1) bad_busy++;
      if (s_vec < prev) bad_order++;
      prev = s_vec;
      tick();
      cycles++;
    end
    start_m = 1'b0;
    start_h = 1'b0;
    checks++;
    if (cycles != 8 * (hold + 1)) begin
      failures++;
      $display("FAIL latency: got %0d cycles, required %0d", cycles, 8 * (hold + 1));
    end
    bad_cnt = 0;
    for (int i = 0; i < 8; i++) if (cnt[i] != hold + 1) bad_cnt++;
    checks++;
    if (bad_cnt != 0 || bad_order != 0) begin
      failures++;
      $display("FAIL vec_hold: %0d vectors with wrong duration, %0d order errors, required 0/0 (%0d cycles each)",
               bad_cnt, bad_order, hold + 1);
    end
    checks++;
    if (bad_acd != 0 || bad_busy != 0 || s_busy !== 1'b0) begin
      failures++;
      $display("FAIL acd_busy: acd errs=%0d busy errs=%0d busy_at_done=%b, required 0/0/0",
               bad_acd, bad_busy, s_busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start_m = 1'b0; start_h = 1'b0; mode = 0; sel = 1'b0;
    #2;
    checks++;
    if ({m_a, m_c, m_d, m_busy, m_done, m_pass} !== 6'b0 || m_err !== 4'd0 || m_vec !== 3'd0) begin
      failures++;
      $display("FAIL reset_async: acd=%b busy=%b done=%b pass=%b err=%0d vec=%0d, required all 0",
               {m_a, m_c, m_d}, m_busy, m_done, m_pass, m_err, m_vec);
    end
    tick(); tick();
    rst = 1'b0;
    tick();
    checks++;
    if ({m_busy, m_done, m_pass, h_busy, h_done} !== 5'b0 || m_err !== 4'd0 || h_err !== 4'd0) begin
      failures++;
      $display("FAIL reset_idle: m busy=%b done=%b pass=%b err=%0d h busy=%b done=%b err=%0d, required all 0",
               m_busy, m_done, m_pass, m_err, h_busy, h_done, h_err);
    end
`ifdef FIRST_FAIL_EN
    checks++;
    if (m_ff !== 3'd0 || m_ffv !== 1'b0) begin
      failures++;
      $display("FAIL reset_ff: first_fail=%0d vld=%b, required 0/0", m_ff, m_ffv);
    end
`endif
  endtask

  task automatic test_correct();
    mode = 0;
    run_sweep(1'b0, 4, 1'b0);
    checks++;
    if (m_done !== 1'b1 || m_pass !== 1'b1 || m_err !== 4'd0) begin
      failures++;
      $display("FAIL correct_result: done=%b pass=%b err=%0d, required 1/1/0", m_done, m_pass, m_err);
    end
    repeat (3) tick();
    checks++;
    if (m_done !== 1'b1 || {m_a, m_c, m_d} !== 3'b111 || m_busy !== 1'b0) begin
      failures++;
      $display("FAIL done_frozen: done=%b acd=%b busy=%b, required 1/111/0", m_done, {m_a, m_c, m_d}, m_busy);
    end
  endtask

  task automatic test_f1_stuck();
    mode = 1;
    run_sweep(1'b0, 4, 1'b0);
    checks++;
    if (m_err !== 4'd4 || m_pass !== 1'b0 || m_done !== 1'b1) begin
      failures++;
      $display("FAIL f1_stuck: err=%0d pass=%b done=%b, required 4/0/1", m_err, m_pass, m_done);
    end
`ifdef FIRST_FAIL_EN
    checks++;
    if (m_ff !== 3'd1 || m_ffv !== 1'b1) begin
      failures++;
      $display("FAIL f1_first_fail: first_fail=%0d vld=%b, required 1/1", m_ff, m_ffv);
    end
`endif
  endtask

  task automatic test_f2_inv();
    mode = 2;
    run_sweep(1'b0, 4, 1'b0);
    checks++;
    if (m_err !== 4'd8 || m_pass !== 1'b0 || m_done !== 1'b1) begin
      failures++;
      $display("FAIL f2_inv: err=%0d pass=%b done=%b, required 8/0/1", m_err, m_pass, m_done);
    end
`ifdef FIRST_FAIL_EN
    checks++;
    if (m_ff !== 3'd0 || m_ffv !== 1'b1) begin
      failures++;
      $display("FAIL f2_first_fail: first_fail=%0d vld=%b, required 0/1", m_ff, m_ffv);
    end
`endif
  endtask

  task automatic test_start_held();
    mode = 1;
    run_sweep(1'b0, 4, 1'b1);
    repeat (5) tick();
    checks++;
    if (m_done !== 1'b1 || m_busy !== 1'b0 || m_err !== 4'd4) begin
      failures++;
      $display("FAIL held_single: done=%b busy=%b err=%0d, required 1/0/4", m_done, m_busy, m_err);
    end
    mode = 0;
    run_sweep(1'b0, 4, 1'b0);
    checks++;
    if (m_done !== 1'b1 || m_pass !== 1'b1 || m_err !== 4'd0) begin
      failures++;
      $display("FAIL held_second: done=%b pass=%b err=%0d, required 1/1/0", m_done, m_pass, m_err);
    end
  endtask

  task automatic test_reset_mid();
    mode = 1;
    sel = 1'b0;
    start_m = 1'b1;
    tick();
    start_m = 1'b0;
    // 19 edges after acceptance the sequencer is in the CHECK cycle of vector 3.
    repeat (19) tick();
    checks++;
    if (m_vec !== 3'd3 || m_err !== 4'd2 || m_busy !== 1'b1) begin
      failures++;
      $display("FAIL mid_position: vec=%0d err=%0d busy=%b, required 3/2/1", m_vec, m_err, m_busy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({m_a, m_c, m_d, m_busy, m_done, m_pass} !== 6'b0 || m_err !== 4'd0 || m_vec !== 3'd0) begin
      failures++;
      $display("FAIL mid_reset: acd=%b busy=%b done=%b pass=%b err=%0d vec=%0d, required all 0",
               {m_a, m_c, m_d}, m_busy, m_done, m_pass, m_err, m_vec);
    end
    tick();
    rst = 1'b0;
    repeat (3) tick();
    checks++;
    if (m_done !== 1'b0 || m_busy !== 1'b0) begin
      failures++;
      $display("FAIL mid_after: done=%b busy=%b, required 0/0", m_done, m_busy);
    end
    mode = 0;
    run_sweep(1'b0, 4, 1'b0);
    checks++;
    if (m_done !== 1'b1 || m_pass !== 1'b1 || m_err !== 4'd0) begin
      failures++;
      $display("FAIL mid_resweep: done=%b pass=%b err=%0d, required 1/1/0", m_done, m_pass, m_err);
    end
  endtask

  task automatic test_hold1();
    mode = 0;
    run_sweep(1'b1, 1, 1'b0);
    checks++;
    if (h_done !== 1'b1 || h_pass !== 1'b1 || h_err !== 4'd0) begin
      failures++;
      $display("FAIL hold1_result: done=%b pass=%b err=%0d, required 1/1/0", h_done, h_pass, h_err);
    end
  endtask

  initial begin
    test_reset();
    test_correct();
    test_f1_stuck();
    test_f2_inv();
    test_start_held();
    test_reset_mid();
    test_hold1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/logic_exerciser.md
Name: logic_exerciser

Overview:
- Self-test sequencer for the 3-input combinational block that has two outputs, F1 (sum-of-products form) and F2 (product-of-sums form).
- Both outputs implement F = (~A&D)|(~A&C)|(C&D), which is majority(~A,C,D).
- On each start, drives all 8 {A,C,D} vectors into the block, waits for outputs to settle, and checks F1 and F2 against an internal golden model.
- Counts mismatches and reports pass/fail. Sits beside the combinational block as its board-level or bench controller.

Parameters:
- HOLD_CYCLES, 4, cycles each vector is held before its check cycle (legal range 1..15).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  pulse or level; sampled in IDLE and DONE only.
- f1_in  input  1  F1 output of the combinational block.
- f2_in  input  1  F2 output of the combinational block.
- a_out  output  1  drives input A of the combinational block.
- c_out  output  1  drives input C.
- d_out  output  1  drives input D.
- busy  output  1  high while a sweep is in progress.
- done  output  1  high from sweep completion until the next start or reset.
- pass  output  1  valid while done=1; 1 iff err_count==0.
- err_count  output  4  mismatching vectors in the current or last sweep (0..8).
- vec_idx  output  3  current vector index.

Behaviour:
- Reset (async, rst=1): state=IDLE; a_out=c_out=d_out=0; busy=0; done=0; pass=0; err_count=0; vec_idx=0; hold counter=0.
- Vector mapping: {a_out,c_out,d_out} = vec_idx, so a_out=vec_idx[2] and d_out=vec_idx[0].
- Golden model: exp = (~a&d)|(~a&c)|(c&d). exp=1 for vectors 1, 2, 3 and 7; exp=0 for vectors 0, 4, 5 and 6.
- All outputs are registered.
- FSM states: IDLE, SETTLE, CHECK, DONE.
- IDLE: start=1 -> SETTLE; vec_idx=0; err_count=0; hold=0; busy=1; done=0.
- SETTLE: vector held on a/c/d_out; hold increments each cycle. After HOLD_CYCLES cycles in SETTLE -> CHECK.
- CHECK (exactly 1 cycle):
  - Sample f1_in and f2_in.
  - A vector counts as one error if f1_in!=exp or f2_in!=exp. It counts once even if both mismatch.
  - If vec_idx==7 -> DONE: busy=0, done=1, pass=(final err_count==0).
  - Otherwise vec_idx+1, hold=0, -> SETTLE.
- DONE: outputs frozen; a/c/d_out keep vector 7. start=1 -> same action as start in IDLE.
- Sweep latency: from the start-sampling edge to done=1 is 8*(HOLD_CYCLES+1) cycles. With default HOLD_CYCLES=4 this is 40 cycles.
- start while busy=1 (SETTLE or CHECK): ignored; no restart, no effect on counters.
- err_count is 4 bits and the maximum is 8, so no saturation logic is needed.
- Reset mid-sweep: immediate return to reset values. A partial result is never reported as done.
- f1_in and f2_in are only sampled in CHECK; glitches during SETTLE have no effect.

Optional Feature:
- Macro: FIRST_FAIL_EN.
- Defined: adds ports first_fail (output, 3 bits) and first_fail_vld (output, 1 bit).
  - On the first mismatching CHECK of a sweep, first_fail latches vec_idx and first_fail_vld goes to 1.
  - Later mismatches do not overwrite it.
  - Both are cleared to 0 by reset and by each accepted start.
- Undefined: these ports and their registers do not exist; all other behaviour is identical.

Test Plan:
- Correct model on f1_in/f2_in, HOLD_CYCLES=4, start pulse -> busy=1 for 40 cycles; a/c/d_out step through 0..7; done=1; pass=1; err_count=0.
- f1_in stuck at 0, f2_in correct -> err_count=4 (vectors 1, 2, 3, 7); pass=0. With FIRST_FAIL_EN: first_fail=1, first_fail_vld=1.
- f2_in = ~exp, f1_in correct -> err_count=8; pass=0. With FIRST_FAIL_EN: first_fail=0.
- start held high for the whole sweep, then a second start pulse while in DONE -> exactly one sweep per accepted start; the second sweep clears err_count and done on its accepting edge.
- rst asserted during the CHECK of vector 3, then deasserted -> all outputs at reset values, done stays 0; a new start gives a full 40-cycle sweep.
- HOLD_CYCLES=1 with the correct model -> done 16 cycles after start; pass=1; each vector driven for exactly 2 cycles.
